// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
//   Shared types and constants for the four-phase channel arbiter.
//   - arb_state_e : transaction phase (IDLE, REQ, ACK, REL)
//   - N_MIN/N_MAX : supported requester count range
//   - TIMEOUT_DEFAULT / CNT_W_DEFAULT : default watchdog limit and counter width
//   - id_width()  : width of a requester index for a given requester count
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    REL  = 2'd3
  } arb_state_e;

  localparam int N_MIN           = 2;
  localparam int N_MAX           = 8;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W_DEFAULT   = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_channel_arbiter_if.sv
// hs_channel_arbiter_if
//   Bundles the left-side requester handshakes, the shared right channel
//   handshake and the arbiter status outputs.
//   Parameters: N (requesters), CNT_W (transaction counter width).
//   Modports:
//     master - environment: drives l_req, r_ack; observes everything else
//     slave  - arbiter: consumes l_req, r_ack; drives l_ack, r_req, gnt_id,
//              busy, err, txn_cnt
interface hs_channel_arbiter_if
  import hs_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = CNT_W_DEFAULT
);
  localparam int ID_W = id_width(N);

  logic [N-1:0]     l_req;
  logic [N-1:0]     l_ack;
  logic             r_req;
  logic             r_ack;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] txn_cnt;

  modport master (
    output l_req, r_ack,
    input  l_ack, r_req, gnt_id, busy, err, txn_cnt
  );

  modport slave (
    input  l_req, r_ack,
    output l_ack, r_req, gnt_id, busy, err, txn_cnt
  );

endinterface

// File: rtl/hs_rr_pick.sv
// hs_rr_pick
//   Combinational N-way circular priority picker. Searches the request
//   vector starting at index ptr and wrapping, returning the first set bit.
//   Ports:
//     req    in  N     request vector
//     ptr    in  ID_W  search start index (must be < N)
//     onehot out N     one-hot winner (zero when no request)
//     idx    out ID_W  winner index (zero when no request)
//     valid  out 1     any request present
//   Build option HS_ARB_ROUND_ROBIN_EN: when undefined the search always
//   starts at 0 (fixed priority, lowest index wins) and ptr is ignored.
module hs_rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  logic [ID_W-1:0] ptr_eff;

`ifdef HS_ARB_ROUND_ROBIN_EN
  assign ptr_eff = ptr;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign ptr_eff    = '0;
`endif

  // cand[k] = (ptr_eff + k) mod N, computed without a divider since
  // ptr_eff + k < 2N.
  logic [ID_W-1:0] cand [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum = {1'b0, ptr_eff} + (ID_W+1)'(gi);
      assign cand[gi] = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N))
                                               : sum[ID_W-1:0];
    end
  endgenerate

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[cand[k]]) begin
        valid             = 1'b1;
        idx               = cand[k];
        onehot[cand[k]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_channel_arbiter.sv
// hs_channel_arbiter
//   Shares one four-phase right channel (r_req/r_ack) between N left
//   requesters. Each granted transaction runs the full return-to-zero
//   sequence IDLE -> REQ -> ACK -> REL -> IDLE; the grant is held until the
//   right side has released (r_ack low).
//   Parameters: N (2..8), TIMEOUT (1..65535 wait cycles before err),
//               CNT_W (completed-transaction counter width).
//   Ports:
//     clk  in  single clock, rising edge
//     rst  in  synchronous, active-low reset
//     bus  slave modport of hs_channel_arbiter_if (l_req/l_ack per
//          requester, r_req/r_ack, gnt_id, busy, err, txn_cnt)
//   Build option HS_ARB_ROUND_ROBIN_EN: circular priority starting one past
//   the last owner; undefined gives fixed priority (lowest index wins).
module hs_channel_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  hs_channel_arbiter_if.slave bus
);

  localparam int ID_W = id_width(N);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e       state_reg,    state_next;
  logic [N-1:0]     l_ack_reg,    l_ack_next;
  logic [N-1:0]     owner_oh_reg, owner_oh_next;
  logic             r_req_reg,    r_req_next;
  logic [ID_W-1:0]  gnt_id_reg,   gnt_id_next;
  logic             busy_reg,     busy_next;
  logic             err_reg,      err_next;
  logic [CNT_W-1:0] txn_cnt_reg,  txn_cnt_next;
  logic [WD_W-1:0]  wd_cnt_reg,   wd_cnt_next;

  logic [ID_W-1:0]  ptr;
  logic [N-1:0]     pick_onehot;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             txn_done;
  logic             wd_wait;

  assign owner_req = |(bus.l_req & owner_oh_reg);
  assign txn_done  = (state_reg == REL) && !bus.r_ack;

`ifdef HS_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_reg, ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (txn_done) begin
      ptr_next = (gnt_id_reg == ID_W'(N - 1)) ? '0 : gnt_id_reg + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end

  assign ptr = ptr_reg;
`else
  assign ptr = '0;
`endif

  hs_rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req    (bus.l_req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_next    = state_reg;
    l_ack_next    = l_ack_reg;
    owner_oh_next = owner_oh_reg;
    r_req_next    = r_req_reg;
    gnt_id_next   = gnt_id_reg;
    busy_next     = busy_reg;
    err_next      = err_reg;
    txn_cnt_next  = txn_cnt_reg;
    wd_cnt_next   = wd_cnt_reg;
    wd_wait       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_next   = pick_idx;
          owner_oh_next = pick_onehot;
          r_req_next    = 1'b1;
          busy_next     = 1'b1;
          wd_cnt_next   = '0;
          state_next    = REQ;
        end
      end
      REQ: begin
        // A dropped owner request is deliberately not looked at here; it
        // is picked up once the channel has acknowledged.
        if (bus.r_ack) begin
          l_ack_next = owner_oh_reg;
          state_next = ACK;
        end else begin
          wd_wait = 1'b1;
        end
      end
      ACK: begin
        if (!owner_req) begin
          r_req_next  = 1'b0;
          wd_cnt_next = '0;
          state_next  = REL;
        end
      end
      REL: begin
        if (!bus.r_ack) begin
          l_ack_next   = '0;
          txn_cnt_next = txn_cnt_reg + CNT_W'(1);
          busy_next    = 1'b0;
          state_next   = IDLE;
        end else begin
          wd_wait = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The counter parks at TIMEOUT-1; the wait that would reach TIMEOUT
    // raises the sticky flag instead, so the count never wraps.
    if (wd_wait) begin
      if (wd_cnt_reg == WD_LAST) err_next = 1'b1;
      else                       wd_cnt_next = wd_cnt_reg + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      l_ack_reg    <= '0;
      owner_oh_reg <= '0;
      r_req_reg    <= 1'b0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      txn_cnt_reg  <= '0;
      wd_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      l_ack_reg    <= l_ack_next;
      owner_oh_reg <= owner_oh_next;
      r_req_reg    <= r_req_next;
      gnt_id_reg   <= gnt_id_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      txn_cnt_reg  <= txn_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
    end
  end

  assign bus.l_ack   = l_ack_reg;
  assign bus.r_req   = r_req_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.busy    = busy_reg;
  assign bus.err     = err_reg;
  assign bus.txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_hs_channel_arbiter.sv
// tb_hs_channel_arbiter
//   Instance A (N=2, TIMEOUT=8, CNT_W=4): cycle vector table plus directed
//   sequences (alternation, watchdog, counter wrap, request during release).
//   Instance B (N=4, defaults): random requesters and partner checked every
//   cycle against a transaction-level reference model.
module tb_hs_channel_arbiter;
  import hs_arb_pkg::*;

  localparam int NA = 2;
  localparam int TA = 8;
  localparam int CA = 4;
  localparam int NB = 4;
  localparam int TB = 255;
  localparam int CB = 16;

`ifdef HS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  hs_channel_arbiter_if #(.N(NA), .CNT_W(CA)) ifa ();
  hs_channel_arbiter_if #(.N(NB), .CNT_W(CB)) ifb ();

  hs_channel_arbiter #(.N(NA), .TIMEOUT(TA), .CNT_W(CA)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  hs_channel_arbiter #(.N(NB), .TIMEOUT(TB), .CNT_W(CB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic       rst;
    logic [1:0] l_req;
    logic       r_ack;
    logic [1:0] l_ack;
    logic       r_req;
    logic       busy;
    logic       gid_chk;
    logic       gid;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  localparam int NVEC = 32;
  vec_t tbl [NVEC];

  task automatic set_vec(input int i, input logic r, input logic [1:0] lq, input logic ra,
                         input logic [1:0] la, input logic rq, input logic bz,
                         input logic gc, input logic gd, input logic er, input logic [3:0] cn);
    tbl[i].rst     = r;
    tbl[i].l_req   = lq;
    tbl[i].r_ack   = ra;
    tbl[i].l_ack   = la;
    tbl[i].r_req   = rq;
    tbl[i].busy    = bz;
    tbl[i].gid_chk = gc;
    tbl[i].gid     = gd;
    tbl[i].err     = er;
    tbl[i].cnt     = cn;
  endtask

  task automatic tick_a();
    @(posedge clk);
    #1;
    chk("a_l_ack_onehot0", 32'($onehot0(ifa.l_ack)), 32'd1);
  endtask

  task automatic reset_a();
    rst_a     = 1'b0;
    ifa.l_req = '0;
    ifa.r_ack = 1'b0;
    tick_a();
    rst_a = 1'b1;
  endtask

  // Well-behaved requesters and a one-cycle echo partner.
  task automatic env_a_step(input logic [NA-1:0] want);
    ifa.r_ack = ifa.r_req;
    for (int i = 0; i < NA; i++) begin
      if (ifa.l_ack[i])  ifa.l_req[i] = 1'b0;
      else if (want[i])  ifa.l_req[i] = 1'b1;
    end
  endtask

  // ---------------- reference model for instance B ----------------
  int         m_owner;
  bit         m_rreq;
  bit         m_lack;
  int         m_cnt;
  int         m_ptr;

  function automatic int m_pick(input logic [NB-1:0] req, input int ptr);
    for (int k = 0; k < NB; k++) begin
      if (req[(ptr + k) % NB]) return (ptr + k) % NB;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [NB-1:0] req, input logic rack);
    if (m_owner < 0) begin
      if (req != '0) begin
        m_owner = m_pick(req, m_ptr);
        m_rreq  = 1'b1;
      end
    end else if (m_rreq && !m_lack) begin
      if (rack) m_lack = 1'b1;
    end else if (m_rreq && m_lack) begin
      if (!req[m_owner]) m_rreq = 1'b0;
    end else begin
      if (!rack) begin
        m_lack = 1'b0;
        m_cnt++;
        $display("B txn %0d completed by requester %0d", m_cnt, m_owner);
        if (RR) m_ptr = (m_owner + 1) % NB;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    int          ngr;
    int          budget;
    logic        prev_busy;
    logic [NB-1:0] e_lack;

    rst_a     = 1'b0;
    rst_b     = 1'b0;
    ifa.l_req = '0;
    ifa.r_ack = 1'b0;
    ifb.l_req = '0;
    ifb.r_ack = 1'b0;

    //        idx rst lreq   rack  lack   rreq busy gchk gid err cnt
    set_vec( 0, 0, 2'b00, 0,    2'b00, 0,   0,   1,   0,  0,  0);
    set_vec( 1, 1, 2'b00, 0,    2'b00, 0,   0,   1,   0,  0,  0);
    set_vec( 2, 1, 2'b01, 0,    2'b00, 1,   1,   1,   0,  0,  0);
    set_vec( 3, 1, 2'b01, 1,    2'b01, 1,   1,   1,   0,  0,  0);
    set_vec( 4, 1, 2'b01, 1,    2'b01, 1,   1,   1,   0,  0,  0);
    set_vec( 5, 1, 2'b00, 1,    2'b01, 0,   1,   1,   0,  0,  0);
    set_vec( 6, 1, 2'b00, 0,    2'b00, 0,   0,   0,   0,  0,  1);
    set_vec( 7, 1, 2'b10, 0,    2'b00, 1,   1,   1,   1,  0,  1);
    set_vec( 8, 1, 2'b10, 1,    2'b10, 1,   1,   1,   1,  0,  1);
    set_vec( 9, 1, 2'b00, 1,    2'b10, 0,   1,   1,   1,  0,  1);
    set_vec(10, 1, 2'b00, 1,    2'b10, 0,   1,   1,   1,  0,  1);
    set_vec(11, 1, 2'b00, 0,    2'b00, 0,   0,   0,   0,  0,  2);
    set_vec(12, 1, 2'b01, 0,    2'b00, 1,   1,   1,   0,  0,  2);
    set_vec(13, 1, 2'b01, 1,    2'b01, 1,   1,   1,   0,  0,  2);
    set_vec(14, 0, 2'b01, 1,    2'b00, 0,   0,   1,   0,  0,  0);
    set_vec(15, 1, 2'b01, 0,    2'b00, 1,   1,   1,   0,  0,  0);
    set_vec(16, 1, 2'b01, 1,    2'b01, 1,   1,   1,   0,  0,  0);
    set_vec(17, 1, 2'b00, 1,    2'b01, 0,   1,   1,   0,  0,  0);
    set_vec(18, 1, 2'b00, 0,    2'b00, 0,   0,   0,   0,  0,  1);
    set_vec(19, 1, 2'b01, 0,    2'b00, 1,   1,   1,   0,  0,  1);
    set_vec(20, 1, 2'b00, 0,    2'b00, 1,   1,   1,   0,  0,  1);
    set_vec(21, 1, 2'b00, 1,    2'b01, 1,   1,   1,   0,  0,  1);
    set_vec(22, 1, 2'b00, 1,    2'b01, 0,   1,   1,   0,  0,  1);
    set_vec(23, 1, 2'b00, 0,    2'b00, 0,   0,   0,   0,  0,  2);
    set_vec(24, 1, 2'b01, 0,    2'b00, 1,   1,   1,   0,  0,  2);
    set_vec(25, 1, 2'b11, 1,    2'b01, 1,   1,   1,   0,  0,  2);
    set_vec(26, 1, 2'b10, 1,    2'b01, 0,   1,   1,   0,  0,  2);
    set_vec(27, 1, 2'b10, 0,    2'b00, 0,   0,   0,   0,  0,  3);
    set_vec(28, 1, 2'b10, 0,    2'b00, 1,   1,   1,   1,  0,  3);
    set_vec(29, 1, 2'b10, 1,    2'b10, 1,   1,   1,   1,  0,  3);
    set_vec(30, 1, 2'b00, 1,    2'b10, 0,   1,   1,   1,  0,  3);
    set_vec(31, 1, 2'b00, 0,    2'b00, 0,   0,   0,   0,  0,  4);

    for (int i = 0; i < NVEC; i++) begin
      rst_a     = tbl[i].rst;
      ifa.l_req = tbl[i].l_req;
      ifa.r_ack = tbl[i].r_ack;
      tick_a();
      chk("vec_l_ack",   32'(ifa.l_ack),   32'(tbl[i].l_ack));
      chk("vec_r_req",   32'(ifa.r_req),   32'(tbl[i].r_req));
      chk("vec_busy",    32'(ifa.busy),    32'(tbl[i].busy));
      chk("vec_err",     32'(ifa.err),     32'(tbl[i].err));
      chk("vec_txn_cnt", 32'(ifa.txn_cnt), 32'(tbl[i].cnt));
      if (tbl[i].gid_chk) chk("vec_gnt_id", 32'(ifa.gnt_id), 32'(tbl[i].gid));
      $display("vec %0d: l_ack=%b r_req=%b busy=%b gnt_id=%0d txn_cnt=%0d",
               i, ifa.l_ack, ifa.r_req, ifa.busy, ifa.gnt_id, ifa.txn_cnt);
    end

    // ---- both requesters always wanting service ----
    reset_a();
    ngr       = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 80 && ngr < 6; c++) begin
      env_a_step(2'b11);
      tick_a();
      if (ifa.busy && !prev_busy) begin
        chk("alt_grant_id", 32'(ifa.gnt_id), RR ? 32'(ngr % 2) : 32'd0);
        $display("grant %0d to requester %0d", ngr, ifa.gnt_id);
        ngr++;
      end
      prev_busy = ifa.busy;
    end
    chk("alt_grant_count", 32'(ngr), 32'd6);
    budget = 0;
    while (budget < 40 && (ifa.busy || ifa.l_req != '0)) begin
      env_a_step(2'b00);
      tick_a();
      budget++;
    end
    chk("alt_drain_idle", 32'(ifa.busy), 32'd0);

    // ---- watchdog with r_ack held low ----
    reset_a();
    ifa.l_req = 2'b01;
    tick_a();
    chk("wd_r_req_grant", 32'(ifa.r_req), 32'd1);
    for (int k = 1; k <= TA; k++) begin
      tick_a();
      chk("wd_err_progress", 32'(ifa.err), (k >= TA) ? 32'd1 : 32'd0);
      chk("wd_r_req_held", 32'(ifa.r_req), 32'd1);
    end
    ifa.r_ack = 1'b1;
    tick_a();
    chk("wd_late_l_ack", 32'(ifa.l_ack), 32'd1);
    ifa.l_req = 2'b00;
    tick_a();
    chk("wd_r_req_release", 32'(ifa.r_req), 32'd0);
    ifa.r_ack = 1'b0;
    tick_a();
    chk("wd_done_busy", 32'(ifa.busy), 32'd0);
    chk("wd_done_cnt", 32'(ifa.txn_cnt), 32'd1);
    chk("wd_err_sticky", 32'(ifa.err), 32'd1);
    rst_a = 1'b0;
    tick_a();
    chk("wd_err_reset", 32'(ifa.err), 32'd0);
    rst_a = 1'b1;
    $display("watchdog transaction complete");

    // ---- 17 transactions into a 4-bit counter ----
    reset_a();
    ngr       = 0;
    prev_busy = 1'b0;
    budget    = 0;
    while (budget < 300 && (ngr < 17 || ifa.busy)) begin
      env_a_step((ngr < 17) ? 2'b01 : 2'b00);
      tick_a();
      if (ifa.busy && !prev_busy) ngr++;
      prev_busy = ifa.busy;
      budget++;
    end
    chk("wrap_grants", 32'(ngr), 32'd17);
    chk("wrap_txn_cnt", 32'(ifa.txn_cnt), 32'(17 % (1 << CA)));
    $display("wrap test: %0d transactions, txn_cnt=%0d", ngr, ifa.txn_cnt);

    // ---- second requester arrives during release of the first ----
    reset_a();
    ifa.l_req = 2'b01;
    tick_a();
    ifa.r_ack = 1'b1;
    tick_a();
    ifa.l_req = 2'b00;
    tick_a();
    chk("rel_l_ack0", 32'(ifa.l_ack), 32'd1);
    ifa.l_req = 2'b10;
    tick_a();
    chk("rel_hold_l_ack", 32'(ifa.l_ack), 32'd1);
    chk("rel_hold_gnt", 32'(ifa.gnt_id), 32'd0);
    chk("rel_hold_r_req", 32'(ifa.r_req), 32'd0);
    ifa.r_ack = 1'b0;
    tick_a();
    chk("rel_idle_l_ack", 32'(ifa.l_ack), 32'd0);
    chk("rel_idle_busy", 32'(ifa.busy), 32'd0);
    tick_a();
    chk("rel_next_gnt", 32'(ifa.gnt_id), 32'd1);
    chk("rel_next_r_req", 32'(ifa.r_req), 32'd1);
    ifa.r_ack = 1'b1;
    tick_a();
    chk("rel_next_l_ack", 32'(ifa.l_ack), 32'd2);
    ifa.l_req = 2'b00;
    tick_a();
    ifa.r_ack = 1'b0;
    tick_a();
    chk("rel_next_cnt", 32'(ifa.txn_cnt), 32'd2);
    $display("release-overlap sequence complete");

    // ---- random traffic on instance B ----
    rst_b   = 1'b1;
    m_owner = -1;
    m_rreq  = 1'b0;
    m_lack  = 1'b0;
    m_cnt   = 0;
    m_ptr   = 0;
    for (int c = 0; c < 1500; c++) begin
      model_step(ifb.l_req, ifb.r_ack);
      @(posedge clk);
      #1;
      e_lack = '0;
      if (m_lack) e_lack[m_owner] = 1'b1;
      chk("rnd_l_ack",   32'(ifb.l_ack),   32'(e_lack));
      chk("rnd_r_req",   32'(ifb.r_req),   32'(m_rreq));
      chk("rnd_busy",    32'(ifb.busy),    (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("rnd_txn_cnt", 32'(ifb.txn_cnt), 32'(m_cnt % 65536));
      chk("rnd_err",     32'(ifb.err),     32'd0);
      if (m_owner >= 0) chk("rnd_gnt_id", 32'(ifb.gnt_id), 32'(m_owner));

      if (ifb.r_ack != ifb.r_req && ($urandom % 2) == 0) ifb.r_ack = ifb.r_req;
      for (int i = 0; i < NB; i++) begin
        if (ifb.l_ack[i]) begin
          if (ifb.l_req[i] && ($urandom % 2) == 0) ifb.l_req[i] = 1'b0;
        end else if (!ifb.l_req[i] && ($urandom % 4) == 0) begin
          ifb.l_req[i] = 1'b1;
        end
      end
    end
    chk("rnd_some_traffic", (m_cnt > 20) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
